// File: rtl/pim_sched_pkg.sv
// Shared constants for the PIM/PNM dispatch path: command classes,
// command width, dispatcher FSM encoding and a cyclic index helper.
package pim_sched_pkg;

  localparam int CMD_W = 5;

  localparam logic [1:0] CLS_PIM = 2'b10;
  localparam logic [1:0] CLS_PNM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARB       = 2'd1,
    ST_PNM_ISSUE = 2'd2,
    ST_PNM_WAIT  = 2'd3
  } state_t;

  // Position 'off' steps after 'base' on a ring of n entries.
  function automatic int ring_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/pim_rr_pick.sv
// Combinational round-robin picker: first set bit of avail at or after ptr,
// searching cyclically. grant is all-zero when avail is empty.
module pim_rr_pick
  import pim_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  avail,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] idx;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = PW'(ring_idx(int'(ptr), off, N));
      if (avail[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pim_dispatch.sv
// Dispatcher below the local scheduler: routes PIM commands round-robin to
// free executors and PNM commands to the single PNM engine over one issue bus.
module pim_dispatch
  import pim_sched_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  BLOCK_SIZE = 1024,
  parameter int  NUM_EXEC   = 2,
  localparam int ADDR_W     = $clog2(BLOCK_SIZE),
  localparam int PTR_W      = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_W-1:0]      cmd,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [ADDR_W-1:0]     addr2,
  input  logic [ADDR_W-1:0]     addr3,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [NUM_EXEC-1:0]   pim_busy,
  output logic [NUM_EXEC-1:0]   pim_start,
  output logic                  pnm_start,
  input  logic                  pnm_done,
  output logic [CMD_W-1:0]      out_cmd,
  output logic [ADDR_W-1:0]     out_a1,
  output logic [ADDR_W-1:0]     out_a2,
  output logic [ADDR_W-1:0]     out_a3,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [7:0]            illegal_cnt,
  output logic                  idle,
  output state_t                state_dbg,
  output logic [PTR_W-1:0]      rr_ptr_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on the FSM state.

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [NUM_EXEC-1:0]   recent_q;
  logic [CMD_W-1:0]      hold_cmd;
  logic [ADDR_W-1:0]     hold_a1, hold_a2, hold_a3;
  logic [DATA_WIDTH-1:0] hold_din;

  logic                  accept;
  logic [1:0]            cls;
  logic                  cls_illegal;
  logic [NUM_EXEC-1:0]   avail;
  logic [NUM_EXEC-1:0]   grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  issue_pim;
  logic                  issue_pnm;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign cls         = cmd[4:3];
  assign cls_illegal = (cls != CLS_PIM) && (cls != CLS_PNM);
  // An executor pulsed last cycle may not show busy yet, so mask it out.
  assign avail       = ~pim_busy & ~recent_q;
  assign idle        = (state_q == ST_IDLE) && (pim_start == '0) && !pnm_start;
  assign state_dbg   = state_q;
  assign rr_ptr_dbg  = rr_ptr_q;

  pim_rr_pick #(
    .N  (NUM_EXEC),
    .PW (PTR_W)
  ) u_pick (
    .avail     (avail),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue_pim = 1'b0;
    issue_pnm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && cls == CLS_PIM)      state_d = ST_ARB;
        else if (accept && cls == CLS_PNM) state_d = ST_PNM_ISSUE;
      end
      ST_ARB: begin
        if (avail != '0) begin
          issue_pim = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PNM_ISSUE: begin
        issue_pnm = 1'b1;
        state_d   = ST_PNM_WAIT;
      end
      ST_PNM_WAIT: begin
        if (pnm_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pim_start   <= '0;
      pnm_start   <= 1'b0;
      recent_q    <= '0;
      rr_ptr_q    <= '0;
      illegal_cnt <= '0;
      hold_cmd    <= '0;
      hold_a1     <= '0;
      hold_a2     <= '0;
      hold_a3     <= '0;
      hold_din    <= '0;
      out_cmd     <= '0;
      out_a1      <= '0;
      out_a2      <= '0;
      out_a3      <= '0;
      out_din     <= '0;
    end else begin
      pim_start <= issue_pim ? grant : '0;
      pnm_start <= issue_pnm;
      recent_q  <= pim_start;
      if (accept) begin
        hold_cmd <= cmd;
        hold_a1  <= addr1;
        hold_a2  <= addr2;
        hold_a3  <= addr3;
        hold_din <= din;
        if (cls_illegal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
      end
      if (issue_pim || issue_pnm) begin
        out_cmd <= hold_cmd;
        out_a1  <= hold_a1;
        out_a2  <= hold_a2;
        out_a3  <= hold_a3;
        out_din <= hold_din;
      end
      if (issue_pim) begin
        rr_ptr_q <= (grant_idx == PTR_W'(NUM_EXEC - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/pim_dispatch.md
Name: pim_dispatch

Overview:
- Sits directly downstream of the local scheduler. Takes one decoded 5-bit scheduler command plus its operands (3 addresses, 1 data word) per handshake.
- PIM-class commands go to a free PIM executor, chosen round-robin. PNM-class commands go to the single PNM engine, and the block holds until that engine reports done.
- Drives one registered issue bus shared by all executors. Each target latches the bus on its own start pulse.

Parameters:
- DATA_WIDTH, 32, width of data operand.
- BLOCK_SIZE, 1024, words per memory block; ADDR_W = $clog2(BLOCK_SIZE) (derived localparam, 10).
- NUM_EXEC, 2, number of PIM executors (≥1).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command/operands valid
- cmd_ready  out  1  dispatcher can accept
- cmd  in  5  decoded scheduler command; [4:3] is class
- addr1, addr2, addr3  in  ADDR_W each  operand addresses
- din  in  DATA_WIDTH  operand data
- pim_busy  in  NUM_EXEC  per-executor busy
- pim_start  out  NUM_EXEC  one-hot, one-cycle issue pulse
- pnm_start  out  1  one-cycle PNM issue pulse
- pnm_done  in  1  PNM completion
- out_cmd  out  5  issued command
- out_a1, out_a2, out_a3  out  ADDR_W  issued addresses
- out_din  out  DATA_WIDTH  issued data
- illegal_cnt  out  8  saturating count of dropped commands
- idle  out  1  state==IDLE and no start pulse active

Behaviour:
- Reset values (rst=1 at an edge): state IDLE, all outputs 0, rr_ptr 0, recent-start mask 0, holding registers 0.
- Reset mid-operation: a pending PIM issue is discarded and a PNM wait is abandoned. Start pulses are never emitted in the cycle after a reset edge.
- cmd_ready is combinational: 1 only in IDLE. Accept occurs when cmd_valid & cmd_ready at an edge.
- Class decoding on cmd[4:3]: 2'b10 is PIM, 2'b11 is PNM, anything else is illegal.
- Illegal commands are accepted and dropped; illegal_cnt increments and saturates at 255. No target sees them.
- FSM states: IDLE, ARB, PNM_ISSUE, PNM_WAIT.
- IDLE, on accept: latch cmd/addr/din into holding registers, then
  - PIM -> ARB
  - PNM -> PNM_ISSUE
  - illegal -> stay IDLE.
- ARB:
  - avail = ~pim_busy & ~recent_mask.
  - If avail != 0, pick the first set bit at or after rr_ptr (cyclic). Register pim_start=onehot(pick), load the out_* bus from the holding registers, set rr_ptr=(pick+1) mod NUM_EXEC, go to IDLE.
  - If avail == 0, stay in ARB and emit nothing.
- PNM_ISSUE: register pnm_start=1, load the out_* bus, go to PNM_WAIT.
- PNM_WAIT: on pnm_done go to IDLE. pnm_done is ignored in every other state.
- Start pulses (pim_start, pnm_start) are high for exactly one cycle.
- out_* buses hold their last issued value until the next issue.
- recent_mask = the pim_start value of the previous cycle. This covers the executor's one-cycle busy-assertion latency, so the same executor is never issued to on consecutive cycles.
- PIM latency: accept at edge N -> ARB during N+1 -> pim_start visible in cycle N+2 (best case). cmd_ready returns high in cycle N+2. Peak throughput is one command per 2 cycles.
- PNM latency: pnm_start in cycle N+2. cmd_ready returns the cycle after pnm_done is sampled in PNM_WAIT.
- Simultaneous cmd_valid and pnm_done while in IDLE: pnm_done is ignored and the command is accepted normally.
- rr_ptr wraps NUM_EXEC-1 -> 0. With NUM_EXEC=1 it stays at 0.

Decomposition:
- Package pim_sched_pkg holds:
  - class localparams CLS_PIM=2'b10, CLS_PNM=2'b11
  - FSM state encodings
  - the command width constant 5.
- One sub-module, pim_rr_pick (combinational): inputs avail[NUM_EXEC] and ptr; outputs onehot grant and grant_idx.

Test Plan:
- Reset, then idle: cmd_ready=1, idle=1. All start pulses and buses 0, illegal_cnt=0.
- PIM, both executors free: cmd=5'b10011, addr1=5, addr2=6, addr3=7, din=32'hA5A5_0001 accepted at edge N -> pim_start=2'b01 in cycle N+2 with out_* equal to those values. A second PIM command is accepted at N+2 -> pim_start=2'b10 at N+4 (round-robin and recent_mask).
- All executors busy: pim_busy=2'b11 with a PIM command pending -> no pulse and cmd_ready=0 for 10 cycles. Drop pim_busy[1] at cycle k -> pim_start=2'b10 at k+1.
- PNM: cmd=5'b11001 -> pnm_start one cycle at N+2, cmd_ready=0 until pnm_done is asserted 20 cycles later, then cmd_ready=1 the following cycle. A stray pnm_done in IDLE causes no effect.
- Illegal: 300 commands with cmd=5'b00101 -> no start pulses, illegal_cnt saturates at 255.
- Reset in PNM_WAIT and in ARB: rst pulse -> next cycle IDLE, cmd_ready=1, rr_ptr=0. A later pnm_done is ignored.
